noc_traffic_gen: RTL

- Initiator at the far end of the processing-element link. Injects 14-bit request flits into the NoC and checks the responses.
- The processing element answers each request with a response flit: bit 13 set, bits [12:1] echoed unchanged, bit 0 inverted.
- Runs a programmable burst in stop-and-wait fashion: one request outstanding at a time, with a response timeout. Reports sent/received/error counts and pass/fail.

---
 rtl/noc_traffic_gen.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/noc_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module  : noc_traffic_gen
// Brief   : Stop-and-wait NoC request injector with response checking and
//           run statistics. Macro TG_LFSR_EN selects LFSR-generated tags.
// Revision: 1.0  initial release
// ============================================================================
module noc_traffic_gen #(
  parameter int FLIT_W  = 14,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_pkts,
  input  logic [3:0]        dest,
  input  logic              full_in,
  output logic              wr_en_out,
  output logic [FLIT_W-1:0] data_out,
  input  logic              wr_en_in,
  input  logic [FLIT_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic [CNT_W-1:0]  rcv_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int c_TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [c_TMR_W-1:0] c_TMO_LAST = c_TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_num;
  logic [3:0]          r_dest;
  logic [CNT_W-1:0]    r_seq;
  logic [c_TMR_W-1:0]  r_timer;
  logic                r_armed;
  logic                r_wr_en_out;
  logic [FLIT_W-1:0]   r_data_out;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [CNT_W-1:0]    r_sent;
  logic [CNT_W-1:0]    r_rcv;
  logic [CNT_W-1:0]    r_err;

  logic [7:0]          w_tag;
  logic [FLIT_W-1:0]   w_expect;
  logic                w_hit;
  logic [CNT_W-1:0]    w_err_inc;
  logic [CNT_W-1:0]    w_rcv_inc;
  logic [CNT_W-1:0]    w_seq_nxt;
  logic                w_pass_nxt;

`ifdef TG_LFSR_EN
  logic [7:0] r_lfsr;
  logic       w_start_ok;
  logic       w_inject;

  assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_inject   = (r_state == S_SEND) && !full_in;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, advanced once per injected flit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 8'h01;
    end else if (w_start_ok) begin
      r_lfsr <= 8'h01;
    end else if (w_inject) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_tag = r_lfsr;
`else
  assign w_tag = 8'(r_seq);
`endif

  // The outstanding request is still in data_out, so the expected response
  // is derived from it rather than from a separate tag copy.
  assign w_expect   = {1'b1, r_data_out[FLIT_W-2:1], ~r_data_out[0]};
  assign w_hit      = wr_en_in && (data_in == w_expect);
  assign w_err_inc  = (r_err == '1) ? r_err : r_err + 1'b1;
  assign w_rcv_inc  = r_rcv + 1'b1;
  assign w_seq_nxt  = r_seq + 1'b1;
  assign w_pass_nxt = (r_err == '0) && w_hit && (w_rcv_inc == r_num);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_dest      <= '0;
      r_seq       <= '0;
      r_timer     <= '0;
      r_armed     <= 1'b0;
      r_wr_en_out <= 1'b0;
      r_data_out  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_sent      <= '0;
      r_rcv       <= '0;
      r_err       <= '0;
    end else begin
      r_wr_en_out <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_num   <= num_pkts;
            r_dest  <= dest;
            r_seq   <= '0;
            r_timer <= '0;
            r_sent  <= '0;
            r_rcv   <= '0;
            r_err   <= '0;
            r_armed <= 1'b1;
            if (num_pkts == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= S_SEND;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end
          end else if (wr_en_in && r_armed) begin
            r_err <= w_err_inc;
          end
        end

        S_SEND: begin
          if (wr_en_in) begin
            r_err <= w_err_inc;
          end
          if (!full_in) begin
            r_data_out  <= {1'b0, r_dest, w_tag, r_seq[0]};
            r_wr_en_out <= 1'b1;
            r_sent      <= r_sent + 1'b1;
            r_timer     <= '0;
            r_state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A response arriving on the timeout cycle takes precedence
          if (wr_en_in || (r_timer == c_TMO_LAST)) begin
            if (w_hit) begin
              r_rcv <= w_rcv_inc;
            end else begin
              r_err <= w_err_inc;
            end
            r_seq <= w_seq_nxt;
            if (w_seq_nxt == r_num) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= w_pass_nxt;
            end else begin
              r_state <= S_SEND;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wr_en_out = r_wr_en_out;
  assign data_out  = r_data_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign sent_cnt  = r_sent;
  assign rcv_cnt   = r_rcv;
  assign err_cnt   = r_err;

endmodule
`default_nettype wire
